// File: rtl/spi_frame_unpacker.sv
// Buffers parallel SPI frames (one active, one pending) and replays each as DATA_DEPTH
// symbols over a valid/ready stream; frames arriving with both buffers full are dropped.
module spi_frame_unpacker #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned DATA_DEPTH = 16,
  parameter int unsigned OVR_W      = 8,
  localparam int unsigned IdxW      = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
  localparam int unsigned FrameW    = DATA_WIDTH * DATA_DEPTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  frame_valid,
  input  logic [FrameW-1:0]     frame_in,
  input  logic                  sym_ready,
  output logic                  sym_valid,
  output logic [DATA_WIDTH-1:0] sym_data,
  output logic [IdxW-1:0]       sym_index,
  output logic                  sym_last,
  output logic                  busy,
  output logic                  overrun,
  output logic [OVR_W-1:0]      overrun_count
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e            state_q, state_d;
  logic [FrameW-1:0] act_q, act_d;
  logic [FrameW-1:0] pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              ovr_q, ovr_d;
  logic [OVR_W-1:0]  ovr_cnt_q, ovr_cnt_d;

  logic xfer, last_xfer;

  assign xfer      = (state_q == StEmit) && sym_ready;
  assign last_xfer = xfer && (idx_q == LastIdx);

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    idx_d      = idx_q;
    ovr_d      = 1'b0;
    ovr_cnt_d  = ovr_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (frame_valid) begin
          act_d   = frame_in;
          idx_d   = '0;
          state_d = StEmit;
        end
      end
      StEmit: begin
        // Active frame is shifted so the current symbol always sits in the top slice.
        if (xfer && !last_xfer) begin
          act_d = act_q << DATA_WIDTH;
          idx_d = idx_q + 1'b1;
        end
        if (last_xfer) begin
          idx_d = '0;
          if (pend_vld_q) begin
            act_d      = pend_q;
            pend_vld_d = frame_valid;
            if (frame_valid) pend_d = frame_in;
          end else if (frame_valid) begin
            act_d = frame_in;
          end else begin
            act_d   = '0;
            state_d = StIdle;
          end
        end else if (frame_valid) begin
          if (!pend_vld_q) begin
            pend_d     = frame_in;
            pend_vld_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
            if (ovr_cnt_q != '1) ovr_cnt_d = ovr_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      idx_q      <= '0;
      ovr_q      <= 1'b0;
      ovr_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      idx_q      <= idx_d;
      ovr_q      <= ovr_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  assign sym_valid     = (state_q == StEmit);
  assign sym_data      = act_q[FrameW-1 -: DATA_WIDTH];
  assign sym_index     = idx_q;
  assign sym_last      = (state_q == StEmit) && (idx_q == LastIdx);
  assign busy          = (state_q == StEmit) || pend_vld_q;
  assign overrun       = ovr_q;
  assign overrun_count = ovr_cnt_q;

endmodule

// File: doc/spi_frame_unpacker.md
Name: spi_frame_unpacker

Overview:
- Sits directly downstream of the SPI receive stage.
- Captures each parallel frame on the single-cycle frame-valid pulse, buffers it, and replays it as DATA_DEPTH symbols of DATA_WIDTH bits each over a valid/ready stream to the core logic.
- Holds one active frame and one pending frame.
- Reports dropped frames when a third frame arrives.

Parameters:
DATA_WIDTH, 2, bits per symbol
DATA_DEPTH, 16, symbols per frame
OVR_W, 8, width of saturating overrun counter

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
frame_valid  input  1  one-cycle pulse; frame_in valid this cycle
frame_in  input  DATA_WIDTH*DATA_DEPTH  parallel frame from SPI receiver
sym_ready  input  1  downstream accepts symbol
sym_valid  output  1  sym_data/sym_index/sym_last valid
sym_data  output  DATA_WIDTH  current symbol
sym_index  output  max(1,$clog2(DATA_DEPTH))  symbol position in frame, 0-based
sym_last  output  1  current symbol is index DATA_DEPTH-1
busy  output  1  active or pending frame held
overrun  output  1  one-cycle pulse: frame dropped
overrun_count  output  OVR_W  dropped frames, saturates at all-ones

Behaviour:
- Interface: one clock (clk); nrst is asynchronous and active-low. All state resets on nrst low, regardless of the clock.
- Reset values:
  - sym_valid=0, sym_data=0, sym_index=0, sym_last=0
  - busy=0, overrun=0, overrun_count=0
  - both buffers cleared; state IDLE
- Symbol order: symbol k = frame_in[W*D-1-k*W -: W]. Symbol 0 is the MSB slice, i.e. the first bits shifted in.
- Handshake:
  - A transfer occurs on a clk edge with sym_valid & sym_ready.
  - While sym_valid=1, sym_data/sym_index/sym_last are stable until the transfer.
  - sym_valid never drops without a transfer except on reset.
- Outputs are registered. Latency: frame_valid in cycle N → sym_valid=1 with index 0 in cycle N+1, when accepted straight into an empty unit.
- States:
  - IDLE: no active frame. On frame_valid, load active, index=0 → EMIT.
  - EMIT: sym_valid=1. On a transfer with index<D-1, increment index.
  - EMIT, transfer at index D-1:
    - if pending held → move pending to active, index=0, stay EMIT (no bubble);
    - else if frame_valid this cycle → load frame_in to active, index=0, stay EMIT;
    - else → IDLE with sym_valid=0 next cycle.
- frame_valid while in EMIT:
  - pending empty (and not consumed as above) → store in pending.
  - pending full and last symbol not transferring this cycle → drop frame_in; overrun=1 next cycle; overrun_count+1, saturating.
  - pending full and last symbol transferring this cycle → pending moves to active, frame_in enters pending; no drop.
- busy = active frame held OR pending held. busy=1 from the cycle after accept until the cycle after the final transfer of the final frame.
- sym_ready is ignored when sym_valid=0.
- Reset mid-frame: all buffers discarded; no partial output after nrst rises; first frame_valid after reset starts at index 0.
- sym_index wraps D-1 → 0 only via a frame change, never inside a frame.

Test Plan:
1. Reset, then frame_valid with frame_in=32'hE4E4_E4E4 and sym_ready=1 held → sym_valid rises next cycle; sym_data sequence 3,2,1,0 repeated 4 times; sym_last only on index 15; sym_valid=0 the cycle after; busy back to 0.
2. Backpressure: frame 32'h0000_0001, sym_ready toggles 1,0,0,1,... → each symbol held stable while ready=0; exactly 16 transfers; last symbol=1, all others 0.
3. Double-buffer, sym_ready=1: frame A=32'hFFFF_FFFF, then frame B=32'h0 four cycles later → 16 symbols of 3, then immediately (no idle cycle) 16 symbols of 0.
4. Overrun: sym_ready=0; send frames A, B, C → C dropped; overrun pulses once; overrun_count=1. Release ready → only A and B emitted (32 transfers).
5. Simultaneous: pending full, frame_valid coincides with transfer of index 15 → no overrun; three frames emitted in order.
6. Reset mid-frame: assert nrst low after 5 transfers → all outputs 0 immediately. After release, new frame 32'h5555_5555 → 16 symbols of 1 starting at index 0. Saturation check: 260 drops → overrun_count=255.
